// File: rtl/pwm_capture.sv
// pwm_capture: synchronizes and glitch-filters a PWM input, then measures the
// high time and period (rising edge to rising edge) of each complete cycle in
// clock ticks. Publishes both counts with a one-cycle valid strobe and flags a
// stalled input with a timeout level.
module pwm_capture #(
  parameter int CNT_W          = 24,
  parameter int FILTER_LEN     = 3,
  parameter int TIMEOUT_CYCLES = 2_700_000
) (
  input  logic             i_sys_clk,
  input  logic             i_rst,
  input  logic             i_pwm,
  output logic [CNT_W-1:0] o_high_cycles,
  output logic [CNT_W-1:0] o_period_cycles,
  output logic             o_valid,
  output logic             o_timeout
);

  localparam int              FW    = 4;
  localparam logic [FW-1:0]   FLEN  = FW'(FILTER_LEN);
  localparam logic [FW-1:0]   FONE  = FW'(1);
  localparam logic [CNT_W-1:0] TMO  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CONE = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

  logic             sync1_q, sync2_q;
  logic             filt_q, filt_d, filt_dly_q;
  logic [FW-1:0]    fcnt_q, fcnt_d;
  logic             rise, fall;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] hc_q, hc_d, pc_q, pc_d;
  logic             valid_q, valid_d, tmo_q, tmo_d;

  // Two-flop synchronizer on the raw asynchronous input.
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= i_pwm;
      sync2_q <= sync1_q;
    end
  end

  // Glitch filter: the level flips on the cycle after FILTER_LEN consecutive
  // differing samples; the sample seen on the flip cycle already counts toward
  // the next change so both edges get identical latency.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    if (fcnt_q == FLEN) begin
      filt_d = ~filt_q;
      fcnt_d = (sync2_q == filt_q) ? FONE : '0;
    end else if (sync2_q != filt_q) begin
      fcnt_d = fcnt_q + FONE;
    end else begin
      fcnt_d = '0;
    end
  end

  // Filter state and one-cycle delayed copy for edge detection.
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      filt_q     <= 1'b0;
      fcnt_q     <= '0;
      filt_dly_q <= 1'b0;
    end else begin
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      filt_dly_q <= filt_q;
    end
  end

  assign rise = filt_q & ~filt_dly_q;
  assign fall = ~filt_q & filt_dly_q;

  // Measurement FSM: cnt restarts at 1 on each rise, so at any edge it holds
  // the number of clocks since the previous rise. Edges win over timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    high_d  = high_q;
    hc_d    = hc_q;
    pc_d    = pc_q;
    valid_d = 1'b0;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rise) begin
          state_d = S_HIGH;
          cnt_d   = CONE;
        end
      end
      S_HIGH: begin
        if (fall) begin
          high_d  = cnt_q;
          cnt_d   = cnt_q + CONE;
          state_d = S_LOW;
        end else if (cnt_q == TMO) begin
          tmo_d   = 1'b1;
          hc_d    = '0;
          pc_d    = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CONE;
        end
      end
      S_LOW: begin
        if (rise) begin
          hc_d    = high_q;
          pc_d    = cnt_q;
          valid_d = 1'b1;
          tmo_d   = 1'b0;
          cnt_d   = CONE;
          state_d = S_HIGH;
        end else if (cnt_q == TMO) begin
          tmo_d   = 1'b1;
          hc_d    = '0;
          pc_d    = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM, counter and published-result registers.
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      high_q  <= '0;
      hc_q    <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      high_q  <= high_d;
      hc_q    <= hc_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
    end
  end

  assign o_high_cycles   = hc_q;
  assign o_period_cycles = pc_q;
  assign o_valid         = valid_q;
  assign o_timeout       = tmo_q;

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures high time and period of an external PWM input, such as an RC receiver channel or an ESC telemetry pulse. It is the input-side counterpart of the LED/PWM pattern generators. The block runs on the 27 MHz system clock. It synchronizes and glitch-filters the input, times each complete high/low cycle in clock ticks, and publishes both counts together with a one-cycle valid strobe. A stalled input raises a timeout flag.

## Interface
Parameters:
- CNT_W, 24: width of the internal counter and of both measurement outputs.
- FILTER_LEN, 3: number of consecutive synchronized samples required to accept a level change. Legal range is 1..15.
- TIMEOUT_CYCLES, 2_700_000: cycles without an accepted edge before the timeout is declared (100 ms at 27 MHz). Must be < 2^CNT_W.

Ports:
- i_sys_clk, input, 1: system clock, 27 MHz, the only clock.
- i_rst, input, 1: asynchronous, active-high reset.
- i_pwm, input, 1: raw asynchronous PWM input.
- o_high_cycles, output, CNT_W: high time of the last complete cycle, in clocks.
- o_period_cycles, output, CNT_W: period of the last complete cycle, in clocks, measured rising edge to rising edge.
- o_valid, output, 1: one-cycle strobe. Asserts when both outputs update together.
- o_timeout, output, 1: level. Set when no edge is seen within TIMEOUT_CYCLES.

## Operation
- Synchronizer: two flops on i_pwm, reset to 0.
- Filter:
  - The filtered level `filt` is reset to 0.
  - A stability counter counts consecutive synchronized samples that differ from `filt`, and clears to 0 on any sample equal to `filt`.
  - When the counter reaches FILTER_LEN, `filt` toggles and the counter clears.
  - A pulse shorter than FILTER_LEN cycles is discarded. A pulse of exactly FILTER_LEN cycles is accepted.
- Edge detect: compares `filt` with `filt` delayed one cycle, producing `rise` and `fall`.
- Counter `cnt`, CNT_W bits:
  - Loaded with 1 on every accepted `rise`.
  - Otherwise incremented each cycle while in HIGH or LOW.
  - Held at 0 in IDLE.
  - At the next edge, `cnt` therefore equals the number of clocks since the previous rise.
- FSM states IDLE, HIGH, LOW; reset state is IDLE:
  - IDLE, on `rise`: go to HIGH and set cnt=1. No publish, because the first cycle is partial.
  - HIGH, on `fall`: latch high_reg=cnt, go to LOW.
  - LOW, on `rise`:
    - Register o_high_cycles=high_reg and o_period_cycles=cnt.
    - Pulse o_valid and clear o_timeout.
    - Set cnt=1 and go to HIGH.
  - HIGH or LOW, when cnt==TIMEOUT_CYCLES and no edge occurs this cycle: set o_timeout=1, clear both measurement outputs to 0, go to IDLE.
- Simultaneous events: an edge on the same cycle as cnt==TIMEOUT_CYCLES takes the edge path, and no timeout is declared.
- Outputs hold their last published values until the next publish or a timeout.

## Timing
- Reset values: o_high_cycles=0, o_period_cycles=0, o_valid=0, o_timeout=0. Also `filt`=0, both sync flops 0, state IDLE.
- A reset assertion mid-measurement aborts immediately. After release, the block waits for a fresh rise, then a full cycle, before the first o_valid.
- Edge latency: an i_pwm transition first sampled at clock edge k appears on `filt` at edge k+2+FILTER_LEN, which is k+5 for the default FILTER_LEN.
- Publish latency: o_valid is high during the cycle after `filt` rises, i.e. edge k+3+FILTER_LEN.
- Both edges see identical latency, so measured widths equal the input widths exactly for clean inputs.
- The minimum measurable input is FILTER_LEN high plus FILTER_LEN low, giving period = 2·FILTER_LEN.
- o_valid is never asserted on two consecutive cycles.

## Test plan
- **Reset:** assert i_rst mid-stream, with i_pwm toggling. All outputs must read 0 while reset is asserted. The first o_valid must not appear until the second accepted rise after release.
- **1 kHz, 25% duty:** drive 6750 cycles high and 20250 cycles low, repeated. From the second rise onward, each period must give o_high_cycles=6750, o_period_cycles=27000, and exactly one o_valid pulse. o_timeout must stay 0.
- **Glitch rejection:** during the low phase of the 1 kHz signal, inject a 2-cycle high pulse. There must be no extra o_valid and the values must be unchanged. Inject a 3-cycle pulse: it must be accepted, giving o_high_cycles=3 for that cycle.
- **Timeout:**
  - Stop the input low after a valid period. o_timeout must rise exactly TIMEOUT_CYCLES clocks after the last rise was accepted, with both outputs going to 0.
  - Restart the input. The first o_valid, after one full period, must clear o_timeout.
- **Minimum period:** drive 3 cycles high and 3 low, repeated. The bench must see o_high_cycles=3, o_period_cycles=6, and o_valid every 6 cycles.
- **Edge/timeout tie:** apply a rise that lands on the same cycle as cnt==TIMEOUT_CYCLES. The block must publish normally, with o_timeout staying 0.
